// File: rtl/rmon_pkg.sv
// Shared definitions for the RMON event counter block.
//   c_rmon_max_events    : largest supported number of event inputs
//   c_rmon_max_cnt_width : widest supported counter
//   f_log2_size          : address width needed to index n items (minimum 1)
//   rmon_rd_rsp_t        : registered read response (data, overflow, valid)
package rmon_pkg;

    localparam int c_rmon_max_events    = 32;
    localparam int c_rmon_max_cnt_width = 32;

    function automatic int f_log2_size(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Data is carried at the widest supported size; the top module uses
    // only the low g_cnt_width bits.
    typedef struct packed {
        logic [c_rmon_max_cnt_width-1:0] data;
        logic                            ovf;
        logic                            valid;
    } rmon_rd_rsp_t;

endpackage

// File: rtl/rmon_cnt_cell.sv
// One RMON event counter: rising-edge detect on its trigger, a counter with
// wrap or saturate behaviour, and a sticky overflow flag.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   trig     : trigger level already in the clk domain
//   en       : counting enable; edges seen while low are discarded
//   clr      : clear counter and overflow flag this cycle
//   cnt      : current count
//   ovf      : sticky overflow flag
module rmon_cnt_cell
    import rmon_pkg::*;
#(
    parameter int g_cnt_width = 32,
    parameter bit g_saturate  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trig,
    input  logic                   en,
    input  logic                   clr,
    output logic [g_cnt_width-1:0] cnt,
    output logic                   ovf
);

    localparam logic [g_cnt_width-1:0] c_cnt_max = '1;

    logic trig_d;
    logic hit;

    // trig_d follows trig regardless of en, so enabling counting while the
    // trigger is already high does not manufacture an edge.
    assign hit = trig & ~trig_d & en;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d <= 1'b0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            trig_d <= trig;
            if (clr) begin
                // An event coinciding with a clear is kept as the first count.
                cnt <= hit ? g_cnt_width'(1) : '0;
                ovf <= 1'b0;
            end else if (hit) begin
                if (cnt == c_cnt_max) begin
                    ovf <= 1'b1;
                    cnt <= g_saturate ? cnt : '0;
                end else begin
                    cnt <= cnt + g_cnt_width'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rmon_event_counter.sv
// RMON event counter bank: one counter per trigger bit, read through an
// addressed port with optional clear-on-read.
// Ports:
//   clk_i, rst_i : system clock, synchronous active-high reset
//   trig_i       : per-event trigger levels/pulses
//   en_i         : global counting enable
//   clr_all_i    : clear every counter and overflow flag
//   rd_i         : one-cycle read strobe for counter rd_addr_i
//   clr_on_rd_i  : with rd_i, also clear the addressed counter
//   rd_valid_o   : one-cycle pulse, rd_data_o/rd_ovf_o valid
//   rd_data_o    : counter value at the time of the read
//   rd_ovf_o     : sticky overflow flag of the read counter
//   ovf_o        : live sticky overflow flags, one per counter
module rmon_event_counter
    import rmon_pkg::*;
#(
    parameter int g_trig_width = 10,
    parameter int g_cnt_width  = 32,
    parameter int g_sync       = 1,
    parameter int g_saturate   = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [g_trig_width-1:0]              trig_i,
    input  logic                                 en_i,
    input  logic                                 clr_all_i,
    input  logic                                 rd_i,
    input  logic [f_log2_size(g_trig_width)-1:0] rd_addr_i,
    input  logic                                 clr_on_rd_i,
    output logic                                 rd_valid_o,
    output logic [g_cnt_width-1:0]               rd_data_o,
    output logic                                 rd_ovf_o,
    output logic [g_trig_width-1:0]              ovf_o
);

    localparam int c_aw = f_log2_size(g_trig_width);

    logic [g_trig_width-1:0] trig_s;
    logic [g_cnt_width-1:0]  cnt [g_trig_width];
    logic [g_trig_width-1:0] ovf;
    logic [g_trig_width-1:0] clr;
    rmon_rd_rsp_t            rsp_d;
    rmon_rd_rsp_t            rsp_q;
    logic                    unused_rsp_bits;

    if (g_sync != 0) begin : g_sync_on
        logic [g_trig_width-1:0] meta;
        logic [g_trig_width-1:0] stab;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                meta <= '0;
                stab <= '0;
            end else begin
                meta <= trig_i;
                stab <= meta;
            end
        end
        assign trig_s = stab;
    end else begin : g_sync_off
        assign trig_s = trig_i;
    end

    for (genvar n = 0; n < g_trig_width; n++) begin : g_cell
        // Out-of-range addresses match no counter, so such reads clear nothing.
        assign clr[n] = clr_all_i |
                        (rd_i & clr_on_rd_i & (rd_addr_i == c_aw'(n)));

        rmon_cnt_cell #(
            .g_cnt_width (g_cnt_width),
            .g_saturate  (g_saturate != 0)
        ) u_cell (
            .clk  (clk_i),
            .rst  (rst_i),
            .trig (trig_s[n]),
            .en   (en_i),
            .clr  (clr[n]),
            .cnt  (cnt[n]),
            .ovf  (ovf[n])
        );
    end

    // Read mux sees the counters before this cycle's updates, so a read
    // returns the pre-clear / pre-increment value.
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = 1'b1;
        for (int n = 0; n < g_trig_width; n++) begin
            if (rd_addr_i == c_aw'(n)) begin
                rsp_d.data = c_rmon_max_cnt_width'(cnt[n]);
                rsp_d.ovf  = ovf[n];
            end
        end
    end

    // Read handshake: rd_i is a one-cycle request with no back-pressure;
    // rd_valid_o pulses exactly one cycle later, one pulse per request.
    // Data and overflow hold their last value while rd_valid_o is low.
    // A request in a reset cycle is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q <= '0;
        end else if (rd_i) begin
            rsp_q <= rsp_d;
        end else begin
            rsp_q.valid <= 1'b0;
        end
    end

    assign rd_valid_o      = rsp_q.valid;
    assign rd_data_o       = rsp_q.data[g_cnt_width-1:0];
    assign rd_ovf_o        = rsp_q.ovf;
    assign ovf_o           = ovf;
    assign unused_rsp_bits = ^rsp_q.data;

endmodule

// File: tb/tb_rmon_event_counter.sv
module tb_rmon_event_counter;

    localparam int T = 10;

    // clock / reset
    logic clk = 1'b0;
    always #8 clk = ~clk;

    logic         rst, en, clr_all, rd, clr_on_rd;
    logic [3:0]   rd_addr;
    logic [T-1:0] trig_a, trig_y;

    logic         rd_valid_a, rd_valid_w, rd_valid_s, rd_valid_y;
    logic [31:0]  rd_data_a, rd_data_y;
    logic [3:0]   rd_data_w, rd_data_s;
    logic         rd_ovf_a, rd_ovf_w, rd_ovf_s, rd_ovf_y;
    logic [T-1:0] ovf_a, ovf_w, ovf_s, ovf_y;

    int checks = 0;
    int errors = 0;
    int exp_cnt [T];
    int exp_y [T];

    // a: direct input, 32-bit wrap; w: 4-bit wrap; s: 4-bit saturate; y: synchronised
    rmon_event_counter #(.g_trig_width(T), .g_cnt_width(32), .g_sync(0), .g_saturate(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .trig_i(trig_a), .en_i(en), .clr_all_i(clr_all),
        .rd_i(rd), .rd_addr_i(rd_addr), .clr_on_rd_i(clr_on_rd),
        .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a), .rd_ovf_o(rd_ovf_a), .ovf_o(ovf_a));
    rmon_event_counter #(.g_trig_width(T), .g_cnt_width(4), .g_sync(0), .g_saturate(0)) dut_w (
        .clk_i(clk), .rst_i(rst), .trig_i(trig_a), .en_i(en), .clr_all_i(clr_all),
        .rd_i(rd), .rd_addr_i(rd_addr), .clr_on_rd_i(clr_on_rd),
        .rd_valid_o(rd_valid_w), .rd_data_o(rd_data_w), .rd_ovf_o(rd_ovf_w), .ovf_o(ovf_w));
    rmon_event_counter #(.g_trig_width(T), .g_cnt_width(4), .g_sync(0), .g_saturate(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .trig_i(trig_a), .en_i(en), .clr_all_i(clr_all),
        .rd_i(rd), .rd_addr_i(rd_addr), .clr_on_rd_i(clr_on_rd),
        .rd_valid_o(rd_valid_s), .rd_data_o(rd_data_s), .rd_ovf_o(rd_ovf_s), .ovf_o(ovf_s));
    rmon_event_counter #(.g_trig_width(T), .g_cnt_width(32), .g_sync(1), .g_saturate(0)) dut_y (
        .clk_i(clk), .rst_i(rst), .trig_i(trig_y), .en_i(en), .clr_all_i(clr_all),
        .rd_i(rd), .rd_addr_i(rd_addr), .clr_on_rd_i(clr_on_rd),
        .rd_valid_o(rd_valid_y), .rd_data_o(rd_data_y), .rd_ovf_o(rd_ovf_y), .ovf_o(ovf_y));

    // scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input int b);
        trig_a[b] = 1'b1;
        tick();
        trig_a[b] = 1'b0;
        tick();
    endtask

    task automatic do_read(input int addr, input logic clr);
        rd        = 1'b1;
        rd_addr   = 4'(addr);
        clr_on_rd = clr;
        tick();
        rd        = 1'b0;
        clr_on_rd = 1'b0;
    endtask

    initial begin
        int k;
        int b;
        int ev;
        int pre;
        logic [T-1:0] v;
        logic [T-1:0] prev;

        rst = 1'b1; en = 1'b1; clr_all = 1'b0; rd = 1'b0; clr_on_rd = 1'b0;
        rd_addr = '0; trig_a = '0; trig_y = '0;
        repeat (3) tick();
        check("rst_valid", 32'(rd_valid_a), 0);
        check("rst_data", rd_data_a, 0);
        check("rst_rd_ovf", 32'(rd_ovf_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);
        rst = 1'b0;
        tick();

        // single pulse on bit 3, read in the same cycle then back-to-back
        trig_a[3] = 1'b1; rd = 1'b1; rd_addr = 4'd3;
        tick();
        check("t1_same_valid", 32'(rd_valid_a), 1);
        check("t1_same_data", rd_data_a, 0);
        trig_a[3] = 1'b0;
        tick();
        check("t1_next_data", rd_data_a, 1);
        rd = 1'b0;
        tick();
        check("t1_valid_drop", 32'(rd_valid_a), 0);
        check("t1_data_hold", rd_data_a, 1);
        do_read(4, 1'b0);
        check("t1_other4", rd_data_a, 0);
        do_read(0, 1'b0);
        check("t1_other0", rd_data_a, 0);

        // level held high counts once; clear-on-read; enable gating
        trig_a[0] = 1'b1;
        repeat (50) tick();
        trig_a[0] = 1'b0;
        tick();
        do_read(0, 1'b1);
        check("t2_held", rd_data_a, 1);
        for (int p = 1; p <= 5; p++) begin
            en = (p == 2 || p == 3) ? 1'b0 : 1'b1;
            pulse_a(0);
        end
        en = 1'b1;
        do_read(0, 1'b0);
        check("t2_en_gate", rd_data_a, 3);
        en = 1'b0; trig_a[5] = 1'b1;
        repeat (2) tick();
        en = 1'b1;
        repeat (3) tick();
        trig_a[5] = 1'b0;
        tick();
        do_read(5, 1'b0);
        check("t2_reenable_high", rd_data_a, 0);

        // 4-bit counters: wrap vs saturate
        repeat (15) pulse_a(1);
        do_read(1, 1'b0);
        check("t3_w15", 32'(rd_data_w), 15);
        check("t3_w15_ovf", 32'(ovf_w[1]), 0);
        pulse_a(1);
        do_read(1, 1'b0);
        check("t3_w16", 32'(rd_data_w), 0);
        check("t3_w16_rdovf", 32'(rd_ovf_w), 1);
        check("t3_w16_ovf", 32'(ovf_w[1]), 1);
        check("t3_s16", 32'(rd_data_s), 15);
        check("t3_s16_ovf", 32'(ovf_s[1]), 1);
        check("t3_a16", rd_data_a, 16);
        check("t3_a16_ovf", 32'(ovf_a[1]), 0);
        pulse_a(1);
        do_read(1, 1'b0);
        check("t3_w17", 32'(rd_data_w), 1);
        check("t3_s17", 32'(rd_data_s), 15);

        // clear-on-read racing an event on the same counter
        repeat (7) pulse_a(2);
        trig_a[2] = 1'b1;
        do_read(2, 1'b1);
        check("t4_pre_clear", rd_data_a, 7);
        trig_a[2] = 1'b0;
        tick();
        do_read(2, 1'b0);
        check("t4_after_clear", rd_data_a, 1);
        trig_a[1] = 1'b1;
        do_read(1, 1'b1);
        check("t4_w_data", 32'(rd_data_w), 1);
        check("t4_w_rdovf", 32'(rd_ovf_w), 1);
        trig_a[1] = 1'b0;
        check("t4_w_ovf_cleared", 32'(ovf_w[1]), 0);
        do_read(1, 1'b0);
        check("t4_w_after", 32'(rd_data_w), 1);
        check("t4_w_rdovf_after", 32'(rd_ovf_w), 0);

        // random pulses against a reference model, clr_all mid-stream
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        check("t5_clr_all_ovf", 32'(ovf_w), 0);
        for (int i = 0; i < T; i++) exp_cnt[i] = 0;
        prev = '0;
        for (int c = 0; c < 60; c++) begin
            v = T'($urandom_range(0, 1023));
            trig_a = v;
            pre = exp_cnt[4];
            if (c == 30) begin
                clr_all = 1'b1; rd = 1'b1; rd_addr = 4'd4;
            end
            tick();
            if (c == 30) begin
                check("t5_read_pre_clear", rd_data_a, 32'(pre));
                clr_all = 1'b0; rd = 1'b0;
            end
            for (int i = 0; i < T; i++) begin
                ev = (v[i] && !prev[i]) ? 1 : 0;
                exp_cnt[i] = (c == 30) ? ev : exp_cnt[i] + ev;
            end
            prev = v;
        end
        trig_a = '0;
        tick();
        for (int i = 0; i < T; i++) begin
            do_read(i, 1'b0);
            check($sformatf("t5_model_%0d", i), rd_data_a, 32'(exp_cnt[i]));
        end

        // reset asserted together with a read: read dropped, all zero after
        rd = 1'b1; rd_addr = 4'd0; rst = 1'b1;
        tick();
        check("t5_rst_rd_dropped", 32'(rd_valid_a), 0);
        rd = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < T; i++) begin
            do_read(i, 1'b0);
            check($sformatf("t5_zero_%0d", i), rd_data_a, 0);
        end

        // synchronised input: 3-cycle latency
        @(posedge clk);
        #12;
        trig_y[7] = 1'b1;
        #10;
        trig_y[7] = 1'b0;
        @(posedge clk);
        #1;
        rd = 1'b1; rd_addr = 4'd7;
        tick();
        check("t6_lat_early_valid", 32'(rd_valid_y), 1);
        check("t6_lat_early", rd_data_y, 0);
        tick();
        check("t6_lat_due", rd_data_y, 1);
        rd = 1'b0;

        // asynchronous 10 ns pulses straddling a clock edge at random offsets
        for (int i = 0; i < T; i++) exp_y[i] = 0;
        exp_y[7] = 1;
        for (int i = 0; i < 20; i++) begin
            b = $urandom_range(0, T - 1);
            k = $urandom_range(1, 9);
            @(posedge clk);
            #(16 - k);
            trig_y[b] = 1'b1;
            #10;
            trig_y[b] = 1'b0;
            exp_y[b] = exp_y[b] + 1;
        end
        repeat (4) tick();
        for (int i = 0; i < T; i++) begin
            do_read(i, 1'b0);
            check($sformatf("t6_async_%0d", i), rd_data_y, 32'(exp_y[i]));
        end

        // out-of-range address: valid pulse, zero data, no clear side effect
        do_read(12, 1'b1);
        check("t6_oor_valid", 32'(rd_valid_y), 1);
        check("t6_oor_data", rd_data_y, 0);
        check("t6_oor_ovf", 32'(rd_ovf_y), 0);
        do_read(7, 1'b0);
        check("t6_oor_no_clear", rd_data_y, 32'(exp_y[7]));

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rmon_event_counter.md
Name: rmon_event_counter

Overview:
Consumes the per-event RMON trigger pulses produced by the switch's RMON event sources (one bit per event type, e.g. frame received/dropped) and accumulates one counter per event. Counters are read by management logic through a simple addressed read port with optional clear-on-read. Sits directly downstream of the RMON trigger generator in simulation and of the real event sources in the switch datapath.

Parameters:
g_trig_width, 10, number of event inputs / counters
g_cnt_width, 32, counter width in bits (2..32)
g_sync, 1, 1 = 2-FF synchroniser on trig_i (inputs may be asynchronous); 0 = trig_i already in clk_i domain
g_saturate, 0, 1 = counter holds at max on overflow; 0 = wraps to 0

Ports:
clk_i  in  1  single system clock
rst_i  in  1  synchronous reset, active-high
trig_i  in  g_trig_width  event trigger levels/pulses, one bit per counter
en_i  in  1  counting enable (global)
clr_all_i  in  1  synchronous clear of all counters and overflow flags
rd_i  in  1  read strobe, one cycle
rd_addr_i  in  clog2(g_trig_width)  counter index to read
clr_on_rd_i  in  1  when high with rd_i, clear the addressed counter
rd_valid_o  out  1  one-cycle pulse, read data valid
rd_data_o  out  g_cnt_width  counter value
rd_ovf_o  out  1  sticky overflow flag of read counter
ovf_o  out  g_trig_width  live sticky overflow flags

Behaviour:
- Reset: rst_i sampled on rising clk_i edge, active-high, synchronous. All counters 0, ovf flags 0, synchroniser/edge regs 0, rd_valid_o 0, rd_data_o 0, rd_ovf_o 0. A read issued in the cycle reset is asserted is dropped (no rd_valid_o).
- Input path: g_sync=1 → trig_i through 2 flops (trig_s); g_sync=0 → trig_s = trig_i. Edge detect: event[n] = trig_s[n] & ~trig_d[n], trig_d registered every cycle. A level held high counts exactly once. Pulse must be ≥1 clk_i period wide to be guaranteed seen.
- Latency trig_i rise → counter updated: 1 cycle (g_sync=0), 3 cycles (g_sync=1).
- en_i=0: events discarded; trig_d still tracks, so re-enable with trig high does not create a count.
- Increment: on event, cnt = cnt+1. At cnt = 2^g_cnt_width-1: ovf[n] set (sticky); cnt holds (g_saturate=1) or becomes 0 (g_saturate=0).
- Read: rd_i in cycle T → rd_valid_o=1 in T+1 with rd_data_o/rd_ovf_o = values before any update in T. rd_data_o/rd_ovf_o hold last value when rd_valid_o=0. rd_addr_i ≥ g_trig_width → rd_valid_o still pulses, data 0, ovf 0, no side effects.
- Clear-on-read: rd_i & clr_on_rd_i in T → addressed cnt and ovf cleared at end of T. Event on same counter in T → cnt = 1 (event never lost), ovf = 0.
- clr_all_i in T: all cnt = 0, all ovf = 0; counters with event in T become 1. Read in same cycle returns pre-clear value.
- Priority per counter per cycle: rst_i > clear (clr_all_i or clear-on-read) > increment; clear+event → 1.
- Back-to-back reads every cycle supported; no internal state machine beyond pipeline regs.

Decomposition:
- Package rmon_pkg: c_rmon_max_events, function f_log2_size, typedef of read response record (data, ovf, valid).
- Sub-module rmon_cnt_cell: one counter + edge detect + ovf flag + clear/increment priority; instantiated g_trig_width times via generate. Top holds synchroniser, read mux and output regs.

Test Plan:
- Reset then single 1-cycle pulse on trig_i[3] (g_sync=0) → cnt[3]=1 one cycle later; read addr 3 → rd_valid_o next cycle, rd_data_o=1, others read 0.
- trig_i[0] held high 50 cycles → cnt[0]=1; 5 separate pulses with en_i=0 for pulses 2–3 → cnt=3.
- g_cnt_width=4: 16 pulses on bit 1 → g_saturate=0: cnt=0, ovf_o[1]=1; g_saturate=1: cnt=15, ovf=1; 17th pulse: 1 / 15.
- cnt[2]=7, read addr 2 with clr_on_rd_i=1 plus event on bit 2 same cycle → rd_data_o=7, cnt[2]=1 afterwards, ovf cleared.
- Random pulses on all 10 bits vs. reference model, clr_all_i mid-stream and rst_i asserted same cycle as rd_i → counts match model, no rd_valid_o for dropped read, all zero after reset.
- g_sync=1, asynchronous 10 ns pulses at random offsets, clk 16 ns → every pulse counted once, 3-cycle latency; rd_addr_i=12 → rd_valid_o=1, data 0.
